// File: rtl/spi_cmd_fsm.sv
// spi_cmd_fsm
// Command controller sitting between the SPI slave byte interface and the
// board-level state output. It parses 1- or 2-byte commands from the master,
// runs a 4-state application FSM and, after every command, loads a status
// byte into the SPI slave transmitter so the master reads the result on its
// next transfer.
//
// Ports
//   i_Clk        block clock, rising edge
//   i_Rst_L      asynchronous active-low reset
//   i_RX_DV      one-cycle strobe, i_RX_Byte valid
//   i_RX_Byte    received opcode or argument byte
//   o_TX_DV      one-cycle strobe, load o_TX_Byte into the slave
//   o_TX_Byte    status {err, ack, cmd_cnt[3:0], state[1:0]}
//   o_State      00 IDLE, 01 RUN, 10 HOLD, 11 FAULT
//   o_Cmd_Err    sticky error flag, cleared by CLEAR or reset
//   o_Cmd_Count  completed commands, wraps 255 -> 0
module spi_cmd_fsm #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TMR_W          = 16
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_RX_DV,
    input  logic [7:0] i_RX_Byte,
    output logic       o_TX_DV,
    output logic [7:0] o_TX_Byte,
    output logic [1:0] o_State,
    output logic       o_Cmd_Err,
    output logic [7:0] o_Cmd_Count
);

    typedef enum logic [1:0] {WAIT_OP, WAIT_ARG, EXEC} pstate_e;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_START = 8'h01;
    localparam logic [7:0] OP_HOLD  = 8'h02;
    localparam logic [7:0] OP_STOP  = 8'h03;
    localparam logic [7:0] OP_CLEAR = 8'h04;
    localparam logic [7:0] OP_SET   = 8'h05;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    pstate_e          ps_q, ps_d;
    logic [7:0]       op_q, op_d;
    logic [7:0]       arg_q, arg_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [1:0]       app_q, app_d;
    logic             err_q, err_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       txb_q, txb_d;
    logic             txdv_q, txdv_d;
    logic             boot_q;

    logic             ack;
    logic [1:0]       app_exec;
    logic [7:0]       cnt_inc;

    assign cnt_inc = cnt_q + 8'd1;

    // Command decode; only meaningful while the parser sits in EXEC.
    always_comb begin
        ack      = 1'b1;
        app_exec = app_q;
        case (op_q)
            OP_NOP:   ack = 1'b1;
            OP_START: if (app_q == ST_IDLE || app_q == ST_HOLD) app_exec = ST_RUN;
                      else ack = 1'b0;
            OP_HOLD:  if (app_q == ST_RUN) app_exec = ST_HOLD;
                      else ack = 1'b0;
            OP_STOP:  if (app_q != ST_FAULT) app_exec = ST_IDLE;
                      else ack = 1'b0;
            OP_CLEAR: app_exec = ST_IDLE;
            OP_SET:   if (arg_q[7:2] == 6'd0) app_exec = arg_q[1:0];
                      else ack = 1'b0;
            default: begin
                app_exec = ST_FAULT;
                ack      = 1'b0;
            end
        endcase
    end

    always_comb begin
        ps_d   = ps_q;
        op_d   = op_q;
        arg_d  = arg_q;
        tmr_d  = tmr_q;
        app_d  = app_q;
        err_d  = err_q;
        cnt_d  = cnt_q;
        txb_d  = txb_q;
        txdv_d = 1'b0;

        case (ps_q)
            WAIT_OP: begin
                if (i_RX_DV) begin
                    op_d  = i_RX_Byte;
                    tmr_d = '0;
                    ps_d  = (i_RX_Byte == OP_SET) ? WAIT_ARG : EXEC;
                end
            end
            WAIT_ARG: begin
                // An argument arriving in the expiry cycle still wins.
                if (i_RX_DV) begin
                    arg_d = i_RX_Byte;
                    ps_d  = EXEC;
                end else if (tmr_q == TMR_LAST) begin
                    ps_d   = WAIT_OP;
                    cnt_d  = cnt_inc;
                    err_d  = 1'b1;
                    txb_d  = {1'b1, 1'b0, cnt_inc[3:0], app_q};
                    txdv_d = 1'b1;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            EXEC: begin
                ps_d  = WAIT_OP;
                app_d = app_exec;
                cnt_d = cnt_inc;
                // A byte landing during EXEC is dropped but flagged as an error.
                err_d  = ((op_q == OP_CLEAR) ? 1'b0 : err_q) | ~ack | i_RX_DV;
                txb_d  = {err_d, ack, cnt_inc[3:0], app_exec};
                txdv_d = 1'b1;
            end
            default: ps_d = WAIT_OP;
        endcase

        // First edge out of reset preloads the slave with an IDLE/ack status,
        // so the master's very first read is meaningful.
        if (boot_q) begin
            txdv_d = 1'b1;
            txb_d  = 8'h40;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            ps_q   <= WAIT_OP;
            op_q   <= '0;
            arg_q  <= '0;
            tmr_q  <= '0;
            app_q  <= ST_IDLE;
            err_q  <= 1'b0;
            cnt_q  <= '0;
            txb_q  <= '0;
            txdv_q <= 1'b0;
            boot_q <= 1'b1;
        end else begin
            ps_q   <= ps_d;
            op_q   <= op_d;
            arg_q  <= arg_d;
            tmr_q  <= tmr_d;
            app_q  <= app_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
            txb_q  <= txb_d;
            txdv_q <= txdv_d;
            boot_q <= 1'b0;
        end
    end

    assign o_TX_DV     = txdv_q;
    assign o_TX_Byte   = txb_q;
    assign o_State     = app_q;
    assign o_Cmd_Err   = err_q;
    assign o_Cmd_Count = cnt_q;

endmodule

// File: tb/tb_spi_cmd_fsm.sv
// Directed bench for spi_cmd_fsm. Inputs change 1 time unit after each rising
// edge; outputs are sampled at the same point.
module tb_spi_cmd_fsm;

    localparam int TO = 1000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_dv = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic [1:0] state;
    logic       cmd_err;
    logic [7:0] cmd_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    spi_cmd_fsm #(.TIMEOUT_CYCLES(TO), .TMR_W(16)) dut (
        .i_Clk       (clk),
        .i_Rst_L     (rst_n),
        .i_RX_DV     (rx_dv),
        .i_RX_Byte   (rx_byte),
        .o_TX_DV     (tx_dv),
        .o_TX_Byte   (tx_byte),
        .o_State     (state),
        .o_Cmd_Err   (cmd_err),
        .o_Cmd_Count (cmd_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".dv"},  tx_dv,   0);
        chk({tag, ".txb"}, tx_byte, 8'h00);
        chk({tag, ".st"},  state,   2'b00);
        chk({tag, ".err"}, cmd_err, 0);
        chk({tag, ".cnt"}, cmd_cnt, 8'h00);
    endtask

    // Release reset away from an edge and check the single preload pulse.
    task automatic release_reset(input string tag);
        rst_n = 1'b1;
        tick();
        chk({tag, ".boot_dv"},  tx_dv,   1);
        chk({tag, ".boot_txb"}, tx_byte, 8'h40);
        chk({tag, ".boot_st"},  state,   2'b00);
        tick();
        chk({tag, ".boot_dv_off"}, tx_dv, 0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_dv = 1'b1; rx_byte = b;
        tick();
        rx_dv = 1'b0;
    endtask

    // Final command byte sampled at edge N; reply must appear at N+1 only.
    task automatic cmd1(input string tag, input logic [7:0] b,
                        input logic [1:0] st, input logic [7:0] txb);
        send_byte(b);
        chk({tag, ".dv_exec"}, tx_dv, 0);
        tick();
        chk({tag, ".dv"},  tx_dv,   1);
        chk({tag, ".txb"}, tx_byte, txb);
        chk({tag, ".st"},  state,   st);
        chk({tag, ".err"}, cmd_err, txb[7]);
        tick();
        chk({tag, ".dv_off"}, tx_dv, 0);
    endtask

    initial begin
        int pulses;

        // Power-on reset
        tick(); tick();
        chk_reset_vals("por");
        release_reset("por");
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            pulses += int'(tx_dv);
        end
        chk("idle_pulses", pulses, 0);

        // START / HOLD / STOP
        cmd1("start", 8'h01, 2'b01, 8'h45);
        cmd1("hold",  8'h02, 2'b10, 8'h4A);
        cmd1("stop",  8'h03, 2'b00, 8'h4C);
        chk("cnt3", cmd_cnt, 8'd3);

        // Fresh reset, then error paths
        rst_n = 1'b0; #1;
        chk_reset_vals("rst2");
        tick();
        release_reset("rst2");
        cmd1("hold_idle", 8'h02, 2'b00, 8'h84);
        cmd1("badop",     8'hFF, 2'b11, 8'h8B);
        cmd1("clear",     8'h04, 2'b00, 8'h4C);

        // SET with valid and invalid arguments
        send_byte(8'h05);
        cmd1("set_ok",  8'h02, 2'b10, 8'h52);
        send_byte(8'h05);
        cmd1("set_bad", 8'h06, 2'b10, 8'h96);

        // Argument timeout: no reply during the window, failed reply at expiry
        send_byte(8'h05);
        pulses = 0;
        for (int i = 1; i < TO; i++) begin
            tick();
            pulses += int'(tx_dv);
        end
        chk("to_window_pulses", pulses, 0);
        tick();
        chk("to.dv",  tx_dv,   1);
        chk("to.txb", tx_byte, 8'h9A);
        chk("to.st",  state,   2'b10);
        chk("to.cnt", cmd_cnt, 8'd6);
        tick();
        chk("to.dv_off", tx_dv, 0);

        // Argument strobed in the exact expiry cycle is accepted
        send_byte(8'h05);
        for (int i = 1; i < TO; i++) tick();
        cmd1("set_at_expiry", 8'h01, 2'b01, 8'hDD);

        // Byte during EXEC is dropped and flags an error
        cmd1("clear2", 8'h04, 2'b00, 8'h60);
        rx_dv = 1'b1; rx_byte = 8'h00;
        tick();
        rx_byte = 8'h01;
        tick();
        rx_dv = 1'b0;
        chk("stray.dv",  tx_dv,   1);
        chk("stray.txb", tx_byte, 8'hE4);
        chk("stray.st",  state,   2'b00);
        chk("stray.err", cmd_err, 1);
        tick();
        chk("stray.dv_off", tx_dv, 0);
        cmd1("nop_after_stray", 8'h00, 2'b00, 8'hE8);
        cmd1("start2",          8'h01, 2'b01, 8'hED);

        // Asynchronous reset while waiting for an argument
        send_byte(8'h05);
        rst_n = 1'b0; #1;
        chk_reset_vals("rst_mid");
        #2;
        release_reset("rst_mid");
        cmd1("after_rst_op", 8'h02, 2'b00, 8'h84);

        // Counter wrap
        for (int i = 0; i < 254; i++) begin
            send_byte(8'h00);
            tick();
        end
        chk("cnt255", cmd_cnt, 8'd255);
        cmd1("wrap", 8'h00, 2'b00, 8'hC0);
        chk("cnt_wrap", cmd_cnt, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_cmd_fsm.md
# spi_cmd_fsm

Command controller for the FPGA-side SPI slave. It consumes the byte stream from the SPI slave receiver, parses 1- or 2-byte commands from the ESP32 master, and drives a 4-state application state machine exported as `o_State`. After every command it loads a status byte into the SPI slave transmitter, so the master reads the resulting state on its next transfer. It runs in the divided SPI system clock domain, between the SPI slave byte interface and the board-level `state` output.

## Interface
- `TIMEOUT_CYCLES`, default 1000: maximum `i_Clk` cycles allowed between an opcode byte and its argument byte.
- `TMR_W`, default 16: width of the argument-timeout counter. It must satisfy 2^TMR_W > TIMEOUT_CYCLES.

- `i_Clk`  in  1  block clock. All logic is rising-edge.
- `i_Rst_L`  in  1  reset, asynchronous, active-low.
- `i_RX_DV`  in  1  one-cycle strobe: `i_RX_Byte` is valid.
- `i_RX_Byte`  in  8  received command or argument byte.
- `o_TX_DV`  out  1  one-cycle strobe: load `o_TX_Byte` into the SPI slave.
- `o_TX_Byte`  out  8  status byte `{o_Cmd_Err, ack, cmd_cnt[3:0], o_State[1:0]}`.
- `o_State`  out  2  application state: 00 IDLE, 01 RUN, 10 HOLD, 11 FAULT.
- `o_Cmd_Err`  out  1  sticky error flag.
- `o_Cmd_Count`  out  8  count of completed commands; wraps from 255 to 0.

## Operation

**Parser FSM**
- States are WAIT_OP, WAIT_ARG and EXEC. Reset state is WAIT_OP.
- WAIT_OP + `i_RX_DV`:
  - Opcode 0x05: latch the opcode and go to WAIT_ARG.
  - Any other opcode: latch the opcode and go to EXEC.
- WAIT_ARG + `i_RX_DV`: latch the argument and go to EXEC.
- WAIT_ARG timeout (see Timing): go to WAIT_OP. The timeout counts as a failed command.
- EXEC is always a single cycle and returns to WAIT_OP.

**Commands** (ack=1 on success; ack=0 sets `o_Cmd_Err`)
- 0x00 NOP: no state change. Ack=1.
- 0x01 START: IDLE→RUN or HOLD→RUN. From RUN or FAULT: ack=0, no change.
- 0x02 HOLD: RUN→HOLD. From any other state: ack=0, no change.
- 0x03 STOP: IDLE/RUN/HOLD→IDLE. From FAULT: ack=0, no change.
- 0x04 CLEAR: any state→IDLE, and clears `o_Cmd_Err`. Ack=1.
- 0x05 SET + arg:
  - If arg[7:2]==0: `o_State`=arg[1:0]. Ack=1.
  - Otherwise: ack=0, no change.
- Any other opcode: `o_State`→FAULT, ack=0.

**Counter and status byte**
- Every completed command increments `o_Cmd_Count`, whether it succeeded, failed or timed out.
- `cmd_cnt` in `o_TX_Byte` is the low nibble of `o_Cmd_Count` after the increment.
- `o_Cmd_Err` is set on any ack=0 event. Only CLEAR or reset clears it.
- If CLEAR is executed, `o_TX_Byte` shows err=0.

## Timing

**Reset values**
- `o_State`=00, `o_Cmd_Err`=0, `o_Cmd_Count`=0, `o_TX_Byte`=0x80? No: `o_TX_Byte`=0x00, `o_TX_DV`=0, parser in WAIT_OP, timer=0.
- Once, on the first `i_Clk` edge after `i_Rst_L` deasserts, `o_TX_DV` pulses for 1 cycle with `o_TX_Byte`=0x40 (ack=1, IDLE). This preloads the slave so the master's first read returns valid status.

**Command latency**
- `i_RX_DV` of the final command byte is sampled at edge N, and the parser enters EXEC.
- At edge N+1: `o_State`, `o_Cmd_Err`, `o_Cmd_Count` and `o_TX_Byte` update together, and `o_TX_DV` goes high for exactly one cycle (N+1 to N+2).
- `o_TX_Byte` holds its value until the next reply.

**Argument timeout**
- The timer clears on entry to WAIT_ARG and increments each cycle while in WAIT_ARG.
- If the timer reaches TIMEOUT_CYCLES-1 with no `i_RX_DV`, the next edge returns to WAIT_OP and emits a reply with ack=0 and no state change.
- If `i_RX_DV` arrives in the same cycle as expiry, the byte wins and is accepted as the argument.

**Boundary conditions**
- `i_RX_DV` during EXEC: the byte is dropped, `o_Cmd_Err` is set, and the reply from the executing command is not otherwise altered.
- `i_Rst_L` asserted mid-command (for example in WAIT_ARG): all registers return immediately and asynchronously to their reset values. Any partial command is discarded.
- Counter at 255 with a completed command: wraps to 0, and the status nibble shows 0.

## Test plan
- Release reset → single `o_TX_DV` pulse with `o_TX_Byte`=0x40 and `o_State`=00; no further `o_TX_DV` pulses while idle.
- Send 0x01 → `o_State`=01 and `o_TX_Byte`=0x45 at edge N+1. Then send 0x02 → `o_State`=10, byte 0x4A. Then send 0x03 → `o_State`=00, byte 0x4C.
- From IDLE, send 0x02 → ack=0, `o_Cmd_Err`=1, byte 0x84. Send 0xFF → `o_State`=11, byte 0x8B. Send 0x04 → `o_State`=00, `o_Cmd_Err`=0, byte 0x4C.
- Send 0x05 then 0x02 → `o_State`=10 and ack=1. Send 0x05 then 0x06 → no change, ack=0.
- Send 0x05 and no argument for TIMEOUT_CYCLES cycles → reply ack=0 with state unchanged. Repeat with the argument strobed in exactly the expiry cycle → SET is applied.
- Issue 256 NOPs → `o_Cmd_Count` wraps to 0 and the status nibble reads 0. Assert `i_Rst_L` low while in WAIT_ARG → all outputs return to reset values immediately.
